cmd_dispatch: RTL and testbench
===============================

// Module: cmd_dispatch
// PURPOSE
//  Sits beside command_sm: decodes the latched Command Code, starts exactly one command-handler SM,
//  reports running/done back to command_sm, and owns the shared response (TX) channel grant.
//  Adds the missing watchdog: a hung handler is aborted and command_sm is released via cmd_sm_done.
// PARAMETERS
//  NUM_HANDLERS    4        number of handler SMs (1..16); handler i serves CC == i
//  CC_WIDTH        32       width of command word
//  TIMEOUT_CYCLES  1000000  max cycles in RUN before abort (>= 2)
//  STAT_W          16       width of statistics counters (CMD_DISPATCH_STATS_EN)
// PORTS
//  clk            in   1             clock
//  reset          in   1             synchronous, active-high
//  command        in   CC_WIDTH      command word from RX FIFO
//  command_le     in   1             latch command (command_sm LATCH_CC)
//  run_cmd_sm     in   1             from command_sm; high START_CC..WAIT_FOR_DONE
//  cmd_sm_running out  1             to command_sm; a handler owns this command
//  cmd_sm_done    out  1             to command_sm; 1-cycle completion pulse
//  hdl_start      out  NUM_HANDLERS  one-hot 1-cycle start pulse
//  hdl_done       in   NUM_HANDLERS  handler completion pulses
//  hdl_abort      out  NUM_HANDLERS  one-hot 1-cycle abort pulse
//  tx_grant       out  NUM_HANDLERS  one-hot response-channel ownership
//  err_illegal    out  1             1-cycle pulse: unknown CC
//  err_timeout    out  1             1-cycle pulse: watchdog fired
//  busy           out  1             state != IDLE
//  cnt_ok/cnt_illegal/cnt_timeout out STAT_W  statistics (0 when feature off)
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; cc_q, legal_q, idx_q, run_q, watchdog, counters 0.
//  Decode on command_le: idx_q <= command[3:0]; legal_q <= command[CC_WIDTH-1:4]==0 && command[3:0]<NUM_HANDLERS.
//  run_rise = run_cmd_sm & ~run_q (run_q registered each cycle). Only run_rise starts a command.
//  States / transitions:
//   IDLE    : run_rise & legal_q -> START; run_rise & ~legal_q -> ILLEGAL (err_illegal pulse on entry)
//   START   : hdl_start[idx_q]=1 for this cycle; watchdog cleared -> RUN
//   RUN     : cmd_sm_running=1, tx_grant[idx_q]=1; watchdog counts up
//             hdl_done[idx_q] -> DONE; count==TIMEOUT_CYCLES-1 -> TIMEOUT; ~run_cmd_sm -> ABORT
//   TIMEOUT : hdl_abort[idx_q]=1, err_timeout=1 for this cycle -> DONE
//   DONE    : cmd_sm_done=1 for this cycle -> IDLE
//   ILLEGAL : no outputs; ~run_cmd_sm -> IDLE
//   ABORT   : hdl_abort[idx_q]=1, no cmd_sm_done -> IDLE (command_sm was reset mid-command)
//  Latency: run_rise at cycle N -> hdl_start at N+1 -> cmd_sm_running at N+2 (command_sm TEST_RUNNING).
//  hdl_done sampled only in RUN; done from non-selected handlers ignored; done same cycle as
//   timeout terminal count -> DONE wins (no abort, no err_timeout).
//  command_le while busy: cc_q/legal_q/idx_q not updated (decode frozen outside IDLE).
//  tx_grant drops the cycle after hdl_done; grant never overlaps start of the next command.
//  Watchdog width = clog2(TIMEOUT_CYCLES); saturates, never wraps.
// CONFIGURATION
//  `CMD_DISPATCH_STATS_EN defined: cnt_ok +1 on DONE entered from RUN, cnt_illegal +1 on ILLEGAL entry,
//   cnt_timeout +1 on TIMEOUT; all saturate at 2**STAT_W-1; cleared only by reset.
//  Undefined: counter logic not built; cnt_* ports tied to 0. Port list identical in both builds.
// STRUCTURE
//  cmd_defs.vh: state localparams, CC field widths (CC_IDX_W=4), handler CC constants.
//  Sub-module cmd_watchdog (clear, enable, expired; param TIMEOUT_CYCLES) for the RUN timer.
//  One registered state vector, combinational outputs decoded from state and idx_q.
// TESTING
//  Legal CC=0x2, handler done 10 cycles after start -> hdl_start=4'b0100 at N+1, running at N+2,
//   tx_grant=4'b0100 during RUN, one cmd_sm_done pulse, cnt_ok=1.
//  CC=0x7 (NUM_HANDLERS=4) -> no hdl_start, running never 1, err_illegal 1 pulse, back IDLE after run drops.
//  TIMEOUT_CYCLES=16, handler silent -> hdl_abort[idx] + err_timeout at cycle 16 of RUN, then cmd_sm_done.
//  Done coincident with terminal count -> cmd_sm_done, no abort, no err_timeout.
//  run_cmd_sm dropped in RUN -> hdl_abort pulse, no cmd_sm_done, busy=0 next cycle.
//  reset asserted in RUN -> all outputs 0 next cycle; stale hdl_done[idx] ignored afterwards.

Source files
------------

// File: rtl/cmd_dispatch_pkg.sv
// Shared state encoding and command-code field widths for the command dispatcher.
package cmd_dispatch_pkg;

    localparam int CC_IDX_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_RUN,
        ST_TIMEOUT,
        ST_DONE,
        ST_ILLEGAL,
        ST_ABORT
    } state_t;

endpackage

// File: rtl/cmd_dispatch_if.sv
// Handshake bundle between command_sm, the dispatcher and the handler SMs.
interface cmd_dispatch_if #(
    parameter int NUM_HANDLERS = 4,
    parameter int CC_WIDTH     = 32
);
    logic [CC_WIDTH-1:0]     command;
    logic                    command_le;
    logic                    run_cmd_sm;
    logic                    cmd_sm_running;
    logic                    cmd_sm_done;
    logic [NUM_HANDLERS-1:0] hdl_start;
    logic [NUM_HANDLERS-1:0] hdl_done;
    logic [NUM_HANDLERS-1:0] hdl_abort;
    logic [NUM_HANDLERS-1:0] tx_grant;

    // master is command_sm plus the handlers; slave is the dispatcher
    modport master (
        output command, command_le, run_cmd_sm, hdl_done,
        input  cmd_sm_running, cmd_sm_done, hdl_start, hdl_abort, tx_grant
    );

    modport slave (
        input  command, command_le, run_cmd_sm, hdl_done,
        output cmd_sm_running, cmd_sm_done, hdl_start, hdl_abort, tx_grant
    );
endinterface

// File: rtl/cmd_dispatch_watchdog.sv
// Saturating RUN-state timer; expired is high once TIMEOUT_CYCLES-1 cycles have been counted.
module cmd_dispatch_watchdog #(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int W = $clog2(TIMEOUT_CYCLES);
    localparam logic [W-1:0] TERM = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] count;

    // Holds at the terminal value so a late decision never sees a wrapped count
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable && count != TERM) begin
            count <= count + W'(1);
        end
    end

    assign expired = (count == TERM);

endmodule

// File: rtl/cmd_dispatch.sv
// Command dispatcher: decodes the latched CC, launches exactly one handler and guards it with a watchdog.
// Statistics counters are built only when CMD_DISPATCH_STATS_EN is defined.
module cmd_dispatch
    import cmd_dispatch_pkg::*;
#(
    parameter int NUM_HANDLERS   = 4,
    parameter int CC_WIDTH       = 32,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int STAT_W         = 16
) (
    input  logic              clk,
    input  logic              reset,
    cmd_dispatch_if.slave     bus,
    output logic              err_illegal,
    output logic              err_timeout,
    output logic              busy,
    output logic [STAT_W-1:0] cnt_ok,
    output logic [STAT_W-1:0] cnt_illegal,
    output logic [STAT_W-1:0] cnt_timeout
);
    state_t                  state;
    logic [CC_IDX_W-1:0]     idx_q;
    logic                    legal_q;
    logic                    run_q;
    logic [NUM_HANDLERS-1:0] sel;
    logic                    run_rise;
    logic                    done_sel;
    logic                    wd_expired;
    logic                    cmd_legal;

    assign run_rise  = bus.run_cmd_sm & ~run_q;
    assign sel       = NUM_HANDLERS'(1) << idx_q;
    assign done_sel  = |(bus.hdl_done & sel);
    assign cmd_legal = (bus.command[CC_WIDTH-1:CC_IDX_W] == '0) &&
                       (int'(bus.command[CC_IDX_W-1:0]) < NUM_HANDLERS);

    cmd_dispatch_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .clear  (state == ST_START),
        .enable (state == ST_RUN),
        .expired(wd_expired)
    );

    // Decode is frozen outside IDLE; a completing handler wins over a coincident timeout
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            idx_q       <= '0;
            legal_q     <= 1'b0;
            run_q       <= 1'b0;
            err_illegal <= 1'b0;
        end else begin
            run_q       <= bus.run_cmd_sm;
            err_illegal <= (state == ST_IDLE) && run_rise && !legal_q;
            case (state)
                ST_IDLE: begin
                    if (bus.command_le) begin
                        idx_q   <= bus.command[CC_IDX_W-1:0];
                        legal_q <= cmd_legal;
                    end
                    if (run_rise) begin
                        state <= legal_q ? ST_START : ST_ILLEGAL;
                    end
                end
                ST_START: state <= ST_RUN;
                ST_RUN: begin
                    if (done_sel) begin
                        state <= ST_DONE;
                    end else if (wd_expired) begin
                        state <= ST_TIMEOUT;
                    end else if (!bus.run_cmd_sm) begin
                        state <= ST_ABORT;
                    end
                end
                ST_TIMEOUT: state <= ST_DONE;
                ST_DONE:    state <= ST_IDLE;
                ST_ILLEGAL: begin
                    if (!bus.run_cmd_sm) begin
                        state <= ST_IDLE;
                    end
                end
                ST_ABORT:   state <= ST_IDLE;
                default:    state <= ST_IDLE;
            endcase
        end
    end

    assign bus.hdl_start      = (state == ST_START) ? sel : '0;
    assign bus.tx_grant       = (state == ST_RUN) ? sel : '0;
    assign bus.hdl_abort      = (state == ST_TIMEOUT || state == ST_ABORT) ? sel : '0;
    assign bus.cmd_sm_running = (state == ST_RUN);
    assign bus.cmd_sm_done    = (state == ST_DONE);
    assign err_timeout        = (state == ST_TIMEOUT);
    assign busy               = (state != ST_IDLE);

`ifdef CMD_DISPATCH_STATS_EN
    localparam logic [STAT_W-1:0] STAT_MAX = '1;

    // Each counter steps on the same edge that enters its state, and sticks at all-ones
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_ok      <= '0;
            cnt_illegal <= '0;
            cnt_timeout <= '0;
        end else begin
            if (state == ST_RUN && done_sel && cnt_ok != STAT_MAX) begin
                cnt_ok <= cnt_ok + STAT_W'(1);
            end
            if (state == ST_IDLE && run_rise && !legal_q && cnt_illegal != STAT_MAX) begin
                cnt_illegal <= cnt_illegal + STAT_W'(1);
            end
            if (state == ST_RUN && !done_sel && wd_expired && cnt_timeout != STAT_MAX) begin
                cnt_timeout <= cnt_timeout + STAT_W'(1);
            end
        end
    end
`else
    assign cnt_ok      = '0;
    assign cnt_illegal = '0;
    assign cnt_timeout = '0;
`endif

endmodule

// File: tb/tb_cmd_dispatch.sv
// Self-checking bench for cmd_dispatch: a per-cycle timeline model built from each issued command,
// compared every cycle, plus literal expectations on observed pulse counts and latencies.
module tb_cmd_dispatch;

    localparam int NUM_H    = 4;
    localparam int T        = 16;
    localparam int SW       = 8;
    localparam int MAXC     = 1024;
    localparam int STAT_MAX = (1 << SW) - 1;
`ifdef CMD_DISPATCH_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic          clk;
    logic          reset;
    logic          err_illegal;
    logic          err_timeout;
    logic          busy;
    logic [SW-1:0] cnt_ok;
    logic [SW-1:0] cnt_illegal;
    logic [SW-1:0] cnt_timeout;

    cmd_dispatch_if #(.NUM_HANDLERS(NUM_H), .CC_WIDTH(32)) bus ();

    cmd_dispatch #(
        .NUM_HANDLERS  (NUM_H),
        .CC_WIDTH      (32),
        .TIMEOUT_CYCLES(T),
        .STAT_W        (SW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .err_illegal(err_illegal),
        .err_timeout(err_timeout),
        .busy       (busy),
        .cnt_ok     (cnt_ok),
        .cnt_illegal(cnt_illegal),
        .cnt_timeout(cnt_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected timeline, one entry per cycle; untouched cycles mean idle
    bit [NUM_H-1:0] exp_start   [MAXC];
    bit [NUM_H-1:0] exp_abort   [MAXC];
    bit [NUM_H-1:0] exp_grant   [MAXC];
    bit             exp_running [MAXC];
    bit             exp_done    [MAXC];
    bit             exp_err_ill [MAXC];
    bit             exp_err_to  [MAXC];
    bit             exp_busy    [MAXC];
    int             exp_cnt     [3][MAXC];

    logic [31:0] m_cc    = '0;
    bit          m_legal = 1'b0;

    int checks = 0;
    int errors = 0;

    int             obs_done          = 0;
    int             obs_ill           = 0;
    int             obs_to            = 0;
    int             obs_abort         = 0;
    int             obs_grant         = 0;
    int             first_rise_cyc    = -1;
    int             first_start_cyc   = -1;
    int             first_running_cyc = -1;
    logic [NUM_H-1:0] first_start_val = '0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s @cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bump_count(input int which, input int from);
        for (int k = from; k < MAXC; k++) begin
            if (exp_cnt[which][k] < STAT_MAX) exp_cnt[which][k]++;
        end
    endtask

    task automatic clear_counts(input int from);
        for (int w = 0; w < 3; w++) begin
            for (int k = from; k < MAXC; k++) exp_cnt[w][k] = 0;
        end
    endtask

    task automatic model_latch(input logic [31:0] cc, input int c);
        if (!exp_busy[c]) begin
            m_cc    = cc;
            m_legal = (cc[31:4] == 28'h0) && (int'(cc[3:0]) < NUM_H);
        end
    endtask

    // kind: 0 handler done, 1 timeout, 2 run dropped, 3 reset in RUN, 4 illegal CC
    task automatic applyStimulus(input logic [31:0] cc, input bit relatch, input bit junk_le,
                                 input int done_after, input int foreign_after,
                                 input int drop_after, input int reset_after);
        int s, run_end, last, kind, idx, fidx, c;
        bit [NUM_H-1:0] oh;
        if (relatch) begin
            tick();
            bus.command    = cc;
            bus.command_le = 1'b1;
            model_latch(cc, cyc);
        end
        tick();
        bus.command_le = 1'b0;
        bus.run_cmd_sm = 1'b1;
        if (first_rise_cyc < 0) first_rise_cyc = cyc;
        s    = cyc + 1;
        idx  = int'(m_cc[3:0]);
        fidx = (idx + 1) % NUM_H;
        oh   = '0;
        if (!m_legal) begin
            kind = 4;
            run_end = s + 3;
            last = run_end + 1;
            exp_err_ill[s] = 1'b1;
            for (int k = s; k <= run_end; k++) exp_busy[k] = 1'b1;
            bump_count(1, s);
        end else begin
            oh[idx] = 1'b1;
            if (reset_after > 0)      begin kind = 3; run_end = s + reset_after; end
            else if (done_after > 0)  begin kind = 0; run_end = s + done_after; end
            else if (drop_after > 0)  begin kind = 2; run_end = s + drop_after; end
            else                      begin kind = 1; run_end = s + T; end
            exp_start[s] = oh;
            exp_busy[s]  = 1'b1;
            for (int k = s + 1; k <= run_end; k++) begin
                exp_running[k] = 1'b1;
                exp_grant[k]   = oh;
                exp_busy[k]    = 1'b1;
            end
            case (kind)
                0: begin
                    exp_done[run_end+1] = 1'b1;
                    exp_busy[run_end+1] = 1'b1;
                    bump_count(0, run_end + 1);
                    last = run_end + 2;
                end
                1: begin
                    exp_abort[run_end+1]  = oh;
                    exp_err_to[run_end+1] = 1'b1;
                    exp_busy[run_end+1]   = 1'b1;
                    exp_done[run_end+2]   = 1'b1;
                    exp_busy[run_end+2]   = 1'b1;
                    bump_count(2, run_end + 1);
                    last = run_end + 3;
                end
                2: begin
                    exp_abort[run_end+1] = oh;
                    exp_busy[run_end+1]  = 1'b1;
                    last = run_end + 2;
                end
                default: begin
                    clear_counts(run_end + 1);
                    last = run_end + 2;
                end
            endcase
        end
        forever begin
            tick();
            c = cyc;
            bus.hdl_done   = '0;
            bus.command_le = 1'b0;
            if (kind == 0 && c == s + done_after) bus.hdl_done[idx] = 1'b1;
            if (kind != 4 && foreign_after > 0 && c == s + foreign_after) bus.hdl_done[fidx] = 1'b1;
            if (junk_le && c == s + 1) begin
                bus.command    = 32'h7;
                bus.command_le = 1'b1;
                model_latch(32'h7, c);
            end
            if ((kind == 2 || kind == 4) && c == run_end) bus.run_cmd_sm = 1'b0;
            if (kind == 3 && c == run_end) begin
                reset          = 1'b1;
                bus.run_cmd_sm = 1'b0;
                m_legal        = 1'b0;
                m_cc           = '0;
            end
            if (kind == 3 && c == run_end + 1) reset = 1'b0;
            if (kind == 3 && c == run_end + 2) bus.hdl_done[idx] = 1'b1;
            if (c == last) bus.run_cmd_sm = 1'b0;
            if (c >= last + 2) break;
        end
        bus.hdl_done = '0;
    endtask

    // Every cycle after the first edge the outputs must match the timeline
    always @(negedge clk) begin
        if (cyc >= 1 && cyc < MAXC) begin
            checkOutput("hdl_start",   32'(bus.hdl_start),      32'(exp_start[cyc]));
            checkOutput("hdl_abort",   32'(bus.hdl_abort),      32'(exp_abort[cyc]));
            checkOutput("tx_grant",    32'(bus.tx_grant),       32'(exp_grant[cyc]));
            checkOutput("running",     32'(bus.cmd_sm_running), 32'(exp_running[cyc]));
            checkOutput("cmd_sm_done", 32'(bus.cmd_sm_done),    32'(exp_done[cyc]));
            checkOutput("err_illegal", 32'(err_illegal),        32'(exp_err_ill[cyc]));
            checkOutput("err_timeout", 32'(err_timeout),        32'(exp_err_to[cyc]));
            checkOutput("busy",        32'(busy),               32'(exp_busy[cyc]));
            checkOutput("cnt_ok",      32'(cnt_ok),      32'(STATS ? exp_cnt[0][cyc] : 0));
            checkOutput("cnt_illegal", 32'(cnt_illegal), 32'(STATS ? exp_cnt[1][cyc] : 0));
            checkOutput("cnt_timeout", 32'(cnt_timeout), 32'(STATS ? exp_cnt[2][cyc] : 0));
            obs_done  <= obs_done  + int'(bus.cmd_sm_done);
            obs_ill   <= obs_ill   + int'(err_illegal);
            obs_to    <= obs_to    + int'(err_timeout);
            obs_abort <= obs_abort + int'(|bus.hdl_abort);
            obs_grant <= obs_grant + int'(|bus.tx_grant);
            if (first_start_cyc < 0 && bus.hdl_start != '0) begin
                first_start_cyc <= cyc;
                first_start_val <= bus.hdl_start;
            end
            if (first_running_cyc < 0 && bus.cmd_sm_running) first_running_cyc <= cyc;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation exceeded its time limit");
        $fatal(1, "[TB] aborted");
    end

    initial begin
        reset          = 1'b1;
        bus.command    = '0;
        bus.command_le = 1'b0;
        bus.run_cmd_sm = 1'b0;
        bus.hdl_done   = '0;
        repeat (3) tick();
        reset = 1'b0;
        repeat (2) tick();

        applyStimulus(32'h2,  1'b1, 1'b0, 10, 0, 0, 0);
        applyStimulus(32'h7,  1'b1, 1'b0, 0,  0, 0, 0);
        applyStimulus(32'h12, 1'b1, 1'b0, 0,  0, 0, 0);
        applyStimulus(32'h1,  1'b1, 1'b0, 0,  0, 0, 0);
        applyStimulus(32'h3,  1'b1, 1'b0, T,  5, 0, 0);
        applyStimulus(32'h0,  1'b1, 1'b0, 0,  0, 5, 0);
        applyStimulus(32'h2,  1'b1, 1'b1, 4,  0, 0, 0);
        applyStimulus(32'h0,  1'b0, 1'b0, 3,  0, 0, 0);

        checkOutput("mid_cnt_ok",      32'(cnt_ok),      STATS ? 32'd4 : 32'd0);
        checkOutput("mid_cnt_illegal", 32'(cnt_illegal), STATS ? 32'd2 : 32'd0);
        checkOutput("mid_cnt_timeout", 32'(cnt_timeout), STATS ? 32'd1 : 32'd0);

        applyStimulus(32'h1,  1'b1, 1'b0, 0,  0, 0, 4);
        applyStimulus(32'h3,  1'b1, 1'b0, 2,  0, 0, 0);
        tick();

        checkOutput("first_start_val", 32'(first_start_val), 32'h4);
        checkOutput("start_latency",   32'(first_start_cyc - first_rise_cyc),   32'd1);
        checkOutput("running_latency", 32'(first_running_cyc - first_rise_cyc), 32'd2);
        checkOutput("done_pulses",     32'(obs_done),  32'd6);
        checkOutput("illegal_pulses",  32'(obs_ill),   32'd2);
        checkOutput("timeout_pulses",  32'(obs_to),    32'd1);
        checkOutput("abort_pulses",    32'(obs_abort), 32'd2);
        checkOutput("grant_cycles",    32'(obs_grant), 32'd60);
        checkOutput("final_cnt_ok",    32'(cnt_ok),    STATS ? 32'd1 : 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
